// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the pool memory arbiter.
// Index widths are derived with idx_w so single-entry configs still get 1 bit.
package mem_arbiter_pkg;

  localparam int DEF_PROC_COUNT = 4;
  localparam int DEF_BUS_W      = 16;
  localparam int ADDR_W         = 8;
  localparam int MEM_WSIZE_W    = 3;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin select: first request
// at or after the pointer, wrapping modulo N.
module mem_arbiter_rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int N  = DEF_PROC_COUNT,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    logic [PW:0]   s;
    logic [PW-1:0] j;
    s     = '0;
    j     = '0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, i_ptr} + (PW+1)'(i);
      if (s >= (PW+1)'(N))
        s = s - (PW+1)'(N);
      j = s[PW-1:0];
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_idx    = j;
        o_gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter from the processor pool onto
// a single-port memory with fixed read latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int PROC_COUNT = DEF_PROC_COUNT,
  parameter int BUS_W      = DEF_BUS_W,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [PROC_COUNT-1:0]   i_req_rd,
  input  logic [PROC_COUNT-1:0]   i_req_wr,
  input  addr_t [PROC_COUNT-1:0]  i_addr,
  input  logic [PROC_COUNT-1:0][BUS_W-1:0]
                                  i_wdata,
  input  logic [PROC_COUNT-1:0][MEM_WSIZE_W-1:0]
                                  i_wr_size,
  output logic [PROC_COUNT-1:0]   o_grant_rd,
  output logic [PROC_COUNT-1:0]   o_grant_wr,
  output logic [PROC_COUNT-1:0]   o_valid,
  output logic [BUS_W-1:0]        o_data,
  output addr_t                   o_mem_addr,
  output logic [BUS_W-1:0]        o_mem_wdata,
  output logic [MEM_WSIZE_W-1:0]  o_mem_wsize,
  output logic                    o_mem_we,
  output logic                    o_mem_re,
  input  logic [BUS_W-1:0]        i_mem_rdata
);

  localparam int PW = idx_w(PROC_COUNT);
  localparam int CW = idx_w(MEM_RD_LAT + 1);

  arb_state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] w_q, w_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BUS_W-1:0] data_q, data_d;
  logic [PROC_COUNT-1:0] grant_rd_q, grant_rd_d;
  logic [PROC_COUNT-1:0] grant_wr_q, grant_wr_d;
  logic [PROC_COUNT-1:0] valid_q, valid_d;
  logic we_q, we_d;
  logic re_q, re_d;

  logic [PROC_COUNT-1:0] pick_gnt;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;
  logic [PW-1:0]         w_nxt;

  mem_arbiter_rr_picker #(
    .N  (PROC_COUNT),
    .PW (PW)
  ) u_pick (
    .i_req (i_req_rd | i_req_wr),
    .i_ptr (ptr_q),
    .o_gnt (pick_gnt),
    .o_idx (pick_idx),
    .o_any (pick_any)
  );

  assign w_nxt = (w_q == PW'(PROC_COUNT - 1))
               ? '0 : w_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      w_q        <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      grant_rd_q <= '0;
      grant_wr_q <= '0;
      valid_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      grant_rd_q <= grant_rd_d;
      grant_wr_q <= grant_wr_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      re_q       <= re_d;
    end
  end

  // A pending write on the winner always beats its read.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          w_d     = pick_idx;
          state_d = i_req_wr[pick_idx]
                  ? WR : RD_ISSUE;
        end
      end
      WR: begin
        state_d = IDLE;
        ptr_d   = w_nxt;
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
        cnt_d   = CW'(MEM_RD_LAT - 1);
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = i_mem_rdata;
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
        ptr_d   = w_nxt;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they
  // appear registered in the cycle the state is entered.
  always_comb begin
    logic [PROC_COUNT-1:0] oh;
    oh         = PROC_COUNT'(1) << w_d;
    grant_wr_d = (state_d == WR) ? oh : '0;
    grant_rd_d = (state_d == RD_ISSUE) ? oh : '0;
    valid_d    = (state_d == RD_DONE) ? oh : '0;
    we_d       = (state_d == WR);
    re_d       = (state_d == RD_ISSUE);
  end

  assign o_grant_rd  = grant_rd_q;
  assign o_grant_wr  = grant_wr_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_mem_we    = we_q;
  assign o_mem_re    = re_q;
  assign o_mem_addr  = (we_q | re_q)
                     ? i_addr[w_q] : '0;
  assign o_mem_wdata = we_q ? i_wdata[w_q] : '0;
  assign o_mem_wsize = we_q ? i_wr_size[w_q] : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction table plus
// hand sequences, checked through an event scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NP  = 4;
  localparam int BW  = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0] i_req_rd, i_req_wr;
  addr_t [NP-1:0] i_addr;
  logic [NP-1:0][BW-1:0] i_wdata;
  logic [NP-1:0][2:0] i_wr_size;
  logic [NP-1:0] o_grant_rd, o_grant_wr, o_valid;
  logic [BW-1:0] o_data, o_mem_wdata, i_mem_rdata;
  addr_t o_mem_addr;
  logic [2:0] o_mem_wsize;
  logic o_mem_we, o_mem_re;

  mem_arbiter #(
    .PROC_COUNT (NP),
    .BUS_W      (BW),
    .MEM_RD_LAT (LAT)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req_rd    (i_req_rd),
    .i_req_wr    (i_req_wr),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_wr_size   (i_wr_size),
    .o_grant_rd  (o_grant_rd),
    .o_grant_wr  (o_grant_wr),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wsize (o_mem_wsize),
    .o_mem_we    (o_mem_we),
    .o_mem_re    (o_mem_re),
    .i_mem_rdata (i_mem_rdata)
  );

  function automatic logic [BW-1:0] mem_f(input addr_t a);
    return (a == 8'h20) ? 16'hDEAD : {a, ~a};
  endfunction

  logic [BW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_f(o_mem_addr);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign i_mem_rdata = pipe[LAT-1];

  typedef struct {
    int cyc;
    int kind;
    logic [NP-1:0] oh;
    addr_t addr;
    logic [BW-1:0] wdata;
    logic [2:0] size;
    logic [BW-1:0] data;
  } ev_t;

  typedef struct {
    int p;
    bit wr;
    addr_t addr;
    logic [BW-1:0] wdata;
    logic [2:0] size;
    logic [BW-1:0] rdata;
  } vec_t;

  ev_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit auto_drop = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      logic [3*NP-1:0] all;
      ev_t a, e;
      all = {o_valid, o_grant_rd, o_grant_wr};
      chk("onehot", 64'($countones(all) <= 1), 64'd1);
      chk("we_vs_grant", o_mem_we, |o_grant_wr);
      chk("re_vs_grant", o_mem_re, |o_grant_rd);
      if (!o_mem_we && !o_mem_re)
        chk("bus_idle", {o_mem_addr, o_mem_wdata, o_mem_wsize}, 0);
      if (|all) begin
        a.cyc   = cyc;
        a.kind  = (|o_grant_wr) ? 0 : (|o_grant_rd) ? 1 : 2;
        a.oh    = o_grant_wr | o_grant_rd | o_valid;
        a.addr  = (a.kind != 2) ? o_mem_addr : '0;
        a.wdata = (a.kind == 0) ? o_mem_wdata : '0;
        a.size  = (a.kind == 0) ? o_mem_wsize : '0;
        a.data  = (a.kind == 2) ? o_data : '0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: kind %0d oh %b at cycle %0d, none required",
                   a.kind, a.oh, cyc);
        end else begin
          e = q.pop_front();
          chk("ev_kind", a.kind, e.kind);
          chk("ev_onehot", a.oh, e.oh);
          if (e.cyc >= 0) chk("ev_cycle", a.cyc, e.cyc);
          chk("ev_addr", a.addr, e.addr);
          chk("ev_wdata", a.wdata, e.wdata);
          chk("ev_wsize", a.size, e.size);
          chk("ev_rdata", a.data, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (auto_drop)
      for (int i = 0; i < NP; i++) begin
        if (o_grant_wr[i]) i_req_wr[i] = 1'b0;
        if (o_valid[i]) i_req_rd[i] = 1'b0;
      end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int c, input int k, input int p,
                      input addr_t a, input logic [BW-1:0] wd,
                      input logic [2:0] s, input logic [BW-1:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.oh = NP'(1) << p;
    e.addr = a; e.wdata = wd; e.size = s; e.data = d;
    q.push_back(e);
  endtask

  task automatic exp_wr(input int c, input int p, input addr_t a,
                        input logic [BW-1:0] d, input logic [2:0] s);
    push(c, 0, p, a, d, s, '0);
  endtask

  task automatic exp_rd(input int c, input int p, input addr_t a,
                        input logic [BW-1:0] d);
    push(c, 1, p, a, '0, '0, '0);
    push(c + 1 + LAT, 2, p, '0, '0, '0, d);
  endtask

  task automatic set_wr(input int p, input addr_t a,
                        input logic [BW-1:0] d, input logic [2:0] s);
    i_addr[p] = a; i_wdata[p] = d; i_wr_size[p] = s;
    i_req_wr[p] = 1'b1;
  endtask

  task automatic set_rd(input int p, input addr_t a);
    i_addr[p] = a;
    i_req_rd[p] = 1'b1;
  endtask

  task automatic wait_q(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d events outstanding, 0 required",
               nm, q.size());
      q.delete();
    end
  endtask

  task automatic drain(input string nm);
    wait_q(nm);
    repeat (3) step();
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {o_grant_rd, o_grant_wr, o_valid, o_mem_we, o_mem_re,
             o_mem_addr, o_mem_wdata, o_mem_wsize}, 0);
    chk({nm, "_data"}, o_data, 0);
  endtask

  vec_t tbl [6];
  int c;

  initial begin
    i_req_rd = '0; i_req_wr = '0; i_addr = '0;
    i_wdata = '0; i_wr_size = '0;
    tbl[0] = '{1, 1'b1, 8'h44, 16'h1234, 3'd1, 16'h0000};
    tbl[1] = '{1, 1'b0, 8'h20, 16'h0000, 3'd0, 16'hDEAD};
    tbl[2] = '{0, 1'b0, 8'h33, 16'h0000, 3'd0, 16'h33CC};
    tbl[3] = '{2, 1'b1, 8'hFE, 16'hFFFF, 3'd7, 16'h0000};
    tbl[4] = '{2, 1'b0, 8'h7F, 16'h0000, 3'd0, 16'h7F80};
    tbl[5] = '{3, 1'b1, 8'h01, 16'h8001, 3'd4, 16'h0000};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    step();
    chk_zero("post_reset");

    c = cyc;
    set_wr(2, 8'h10, 16'hA5A5, 3'd3);
    exp_wr(c + 1, 2, 8'h10, 16'hA5A5, 3'd3);
    drain("t1_write");

    c = cyc;
    set_wr(0, 8'h01, 16'h0001, 3'd1);
    set_wr(3, 8'h03, 16'h0003, 3'd2);
    exp_wr(c + 1, 3, 8'h03, 16'h0003, 3'd2);
    exp_wr(c + 3, 0, 8'h01, 16'h0001, 3'd1);
    drain("t1_ptr3");

    foreach (tbl[n]) begin
      c = cyc;
      if (tbl[n].wr) begin
        set_wr(tbl[n].p, tbl[n].addr, tbl[n].wdata, tbl[n].size);
        exp_wr(c + 1, tbl[n].p, tbl[n].addr, tbl[n].wdata, tbl[n].size);
      end else begin
        set_rd(tbl[n].p, tbl[n].addr);
        exp_rd(c + 1, tbl[n].p, tbl[n].addr, tbl[n].rdata);
      end
      drain("table");
    end

    auto_drop = 1'b0;
    c = cyc;
    for (int p = 0; p < NP; p++)
      set_wr(p, addr_t'(8'h80 + p), BW'(16'hC000 + p), 3'(p));
    for (int k = 0; k < 5; k++)
      exp_wr(c + 1 + 2*k, k % NP, addr_t'(8'h80 + k % NP),
             BW'(16'hC000 + k % NP), 3'(k % NP));
    wait_q("t3_rr");
    i_req_wr = '0;
    auto_drop = 1'b1;
    repeat (3) step();

    c = cyc;
    set_wr(3, 8'h5C, 16'hBEEF, 3'd5);
    i_req_rd[3] = 1'b1;
    exp_wr(c + 1, 3, 8'h5C, 16'hBEEF, 3'd5);
    exp_rd(c + 3, 3, 8'h5C, 16'h5CA3);
    drain("t4_wr_rd");

    c = cyc;
    set_wr(3, 8'h13, 16'h0303, 3'd2);
    set_wr(0, 8'h10, 16'h0101, 3'd1);
    exp_wr(c + 1, 0, 8'h10, 16'h0101, 3'd1);
    exp_wr(c + 3, 3, 8'h13, 16'h0303, 3'd2);
    drain("t4_wrap");

    c = cyc;
    set_rd(0, 8'h66);
    exp_rd(c + 1, 0, 8'h66, 16'h6699);
    step();
    step();
    i_addr[1] = 8'h77; i_wdata[1] = 16'h7777;
    i_req_wr[1] = 1'b1;
    step();
    step();
    i_req_wr[1] = 1'b0;
    drain("t6_drop");
    repeat (4) step();

    c = cyc;
    set_wr(1, 8'h21, 16'h2121, 3'd6);
    exp_wr(c + 1, 1, 8'h21, 16'h2121, 3'd6);
    drain("t5_pre");

    c = cyc;
    set_rd(1, 8'h20);
    push(c + 1, 1, 1, 8'h20, '0, '0, '0);
    step();
    step();
    rstn = 1'b0;
    #1;
    chk_zero("rst_mid_read");
    i_req_rd = '0;
    step();
    step();
    rstn = 1'b1;
    wait_q("t5_grant");
    step();
    c = cyc;
    set_wr(2, 8'h42, 16'h4242, 3'd2);
    set_wr(0, 8'h40, 16'h4040, 3'd0);
    exp_wr(c + 1, 0, 8'h40, 16'h4040, 3'd0);
    exp_wr(c + 3, 2, 8'h42, 16'h4242, 3'd2);
    drain("t5_after");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at 100000");
    $fatal(1);
  end

endmodule
